// File: rtl/freq_sched_pkg.sv
// Shared constants and FSM encoding for the note-to-period ROM scheduler.
package freq_sched_pkg;

  localparam int NOTE_W   = 7;
  localparam int PERIOD_W = 16;

  // ROM reset word: A4 (note 69) maps to period 916.
  localparam logic [15:0] PERIOD_RESET = 16'd916;
  localparam logic [6:0]  NOTE_RESET   = 7'd69;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } sched_state_e;

endpackage

// File: rtl/freq_rom_voice_sched_rr_arb.sv
// Combinational round-robin winner select: the search starts one position
// above the pointer and wraps, so the last winner has the lowest priority.
module rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Walk the candidates from ptr+1 upward; the first requester wins.
  always_comb begin
    int               c;
    logic [IDX_W-1:0] ci;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    c       = 0;
    ci      = '0;
    for (int k = 1; k <= N; k++) begin
      c  = (int'(i_ptr) + k) % N;
      ci = IDX_W'(c);
      if (!o_valid && i_req[ci]) begin
        o_valid   = 1'b1;
        o_gnt[ci] = 1'b1;
        o_idx     = ci;
      end
    end
  end

endmodule

// File: rtl/freq_rom_voice_sched.sv
// Time-shares one registered note-to-period ROM between N_VOICE voices.
// Handshake: a voice raises req[v] (level) with a stable note and holds it
// until ack[v] pulses for one cycle together with rsp_period/rsp_voice/
// rsp_bad; it drops req at the edge that ends the ack cycle. A lookup is never
// aborted by req falling; only rstn kills an in-flight lookup (no ack).
module freq_rom_voice_sched #(
  parameter int N_VOICE  = 4,
  parameter int NOTE_W   = freq_sched_pkg::NOTE_W,
  parameter int PERIOD_W = freq_sched_pkg::PERIOD_W
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_VOICE-1:0]        req,
  input  logic [N_VOICE*NOTE_W-1:0] note,
  output logic [N_VOICE-1:0]        ack,
  output logic [PERIOD_W-1:0]       rsp_period,
  output logic [2:0]                rsp_voice,
  output logic                      rsp_bad,
  output logic                      busy,
  output logic                      rom_en,
  output logic [NOTE_W-1:0]         rom_addr,
  input  logic [PERIOD_W-1:0]       rom_data
);

  import freq_sched_pkg::*;

  localparam int IDX_W = (N_VOICE > 1) ? $clog2(N_VOICE) : 1;

  sched_state_e       r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt;
  logic [N_VOICE-1:0] r_gnt_oh;

  logic [N_VOICE-1:0] w_req_m;
  logic [N_VOICE-1:0] w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_valid;
  logic [NOTE_W-1:0]  w_win_note;

  // A voice being acked this cycle must not be regranted on the same edge.
  assign w_req_m = req & ~ack;
  assign busy    = (r_state != S_IDLE);

  rr_arb #(
    .N     (N_VOICE),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (w_req_m),
    .i_ptr   (r_ptr),
    .o_gnt   (w_win_oh),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  // Select the winning voice's note slice with constant-base slices.
  always_comb begin
    w_win_note = '0;
    for (int v = 0; v < N_VOICE; v++) begin
      if (w_win_idx == IDX_W'(v)) w_win_note = note[v*NOTE_W +: NOTE_W];
    end
  end

  // Lookup sequencer: grant, present address for one ROM cycle, capture, ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ptr      <= IDX_W'(N_VOICE - 1);
      r_gnt      <= '0;
      r_gnt_oh   <= '0;
      rom_en     <= 1'b0;
      rom_addr   <= NOTE_W'(NOTE_RESET);
      rsp_period <= PERIOD_W'(PERIOD_RESET);
      rsp_voice  <= 3'd0;
      rsp_bad    <= 1'b0;
      ack        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ack <= '0;
          if (w_win_valid) begin
            r_gnt    <= w_win_idx;
            r_gnt_oh <= w_win_oh;
            rom_addr <= w_win_note;
            rom_en   <= 1'b1;
            r_state  <= S_READ;
          end else begin
            rom_en <= 1'b0;
          end
        end
        S_READ: begin
          // ROM samples rom_addr at this edge; its data is valid next cycle.
          rom_en  <= 1'b0;
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          rsp_period <= rom_data;
          rsp_bad    <= (rom_data == '0);
          rsp_voice  <= 3'(r_gnt);
          ack        <= r_gnt_oh;
          r_ptr      <= r_gnt;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          ack     <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_rom_voice_sched.sv
// Directed bench for freq_rom_voice_sched with a registered ROM model.
module tb_freq_rom_voice_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] note = '0;
  logic [3:0]  ack;
  logic [15:0] rsp_period;
  logic [2:0]  rsp_voice;
  logic        rsp_bad;
  logic        busy;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  freq_rom_voice_sched #(.N_VOICE(4), .NOTE_W(7), .PERIOD_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .note       (note),
    .ack        (ack),
    .rsp_period (rsp_period),
    .rsp_voice  (rsp_voice),
    .rsp_bad    (rsp_bad),
    .busy       (busy),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data)
  );

  // ROM model: equal-tempered periods for the notes used here, 0 out of range.
  function automatic logic [15:0] rom_word(input logic [6:0] a);
    if (a < 7'd12 || a > 7'd119) return 16'd0;
    case (a)
      7'd12:   return 16'd24660;
      7'd60:   return 16'd1541;
      7'd64:   return 16'd1223;
      7'd67:   return 16'd1029;
      7'd69:   return 16'd916;
      7'd72:   return 16'd771;
      7'd119:  return 16'd51;
      default: return 16'd1000;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) rom_data <= 16'd916;
    else if (rom_en) rom_data <= rom_word(rom_addr);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_note(input int v, input logic [6:0] n);
    note[v*7 +: 7] = n;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = '0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    total++; if (rom_addr !== 7'd69) begin bad++; $display("FAIL reset_rom_addr got=%0d exp=69", rom_addr); end
    total++; if (rsp_period !== 16'd916) begin bad++; $display("FAIL reset_rsp_period got=%0d exp=916", rsp_period); end
    total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rsp_voice !== 3'd0 || rsp_bad !== 1'b0) begin bad++; $display("FAIL reset_rsp got voice=%0d bad=%b exp 0/0", rsp_voice, rsp_bad); end
  endtask

  task automatic test_single();
    req[2] = 1'b1;
    set_note(2, 7'd69);
    tick();
    total++; if (rom_en !== 1'b1 || rom_addr !== 7'd69) begin bad++; $display("FAIL single_t1_rom got en=%b addr=%0d exp en=1 addr=69", rom_en, rom_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_t1_busy got=%b exp=1", busy); end
    tick();
    total++; if (busy !== 1'b1 || ack !== 4'b0 || rom_en !== 1'b0) begin bad++; $display("FAIL single_t2 got busy=%b ack=%b en=%b exp 1/0000/0", busy, ack, rom_en); end
    tick();
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", ack); end
    total++; if (rsp_period !== 16'd916 || rsp_voice !== 3'd2 || rsp_bad !== 1'b0) begin bad++; $display("FAIL single_rsp got p=%0d v=%0d b=%b exp 916/2/0", rsp_period, rsp_voice, rsp_bad); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_t3_busy got=%b exp=1", busy); end
    req[2] = 1'b0;
    tick();
    total++; if (ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_t4 got ack=%b busy=%b exp 0000/0", ack, busy); end
  endtask

  task automatic test_boundaries();
    logic [6:0]  notes [4] = '{7'd12, 7'd119, 7'd5, 7'd127};
    logic [15:0] exp_p [4] = '{16'd24660, 16'd51, 16'd0, 16'd0};
    logic        exp_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      logic got;
      got = 1'b0;
      req[1] = 1'b1;
      set_note(1, notes[i]);
      for (int c = 0; c < 10 && !got; c++) begin
        tick();
        if (ack != 4'b0) got = 1'b1;
      end
      total++;
      if (!got) begin
        bad++; $display("FAIL bnd_timeout note=%0d got no ack exp ack", notes[i]);
      end else begin
        if (ack !== 4'b0010 || rsp_voice !== 3'd1 || rsp_period !== exp_p[i] || rsp_bad !== exp_b[i]) begin
          bad++;
          $display("FAIL bnd_note%0d got ack=%b v=%0d p=%0d b=%b exp 0010/1/%0d/%b",
                   notes[i], ack, rsp_voice, rsp_period, rsp_bad, exp_p[i], exp_b[i]);
        end
      end
      req[1] = 1'b0;
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_p [4] = '{16'd1541, 16'd1223, 16'd1029, 16'd771};
    int k;
    int last;
    rstn = 1'b0;
    tick();
    req = 4'b1111;
    set_note(0, 7'd60); set_note(1, 7'd64); set_note(2, 7'd67); set_note(3, 7'd72);
    tick();
    rstn = 1'b1;
    k = 0;
    last = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      tick();
      if (ack != 4'b0) begin
        total++;
        if (ack !== (4'b0001 << k) || rsp_voice !== 3'(k) || rsp_period !== exp_p[k]) begin
          bad++;
          $display("FAIL rr_ack%0d got ack=%b v=%0d p=%0d exp ack=%b v=%0d p=%0d",
                   k, ack, rsp_voice, rsp_period, 4'b0001 << k, k, exp_p[k]);
        end
        if (k > 0) begin
          total++;
          if (cyc - last != 4) begin bad++; $display("FAIL rr_spacing%0d got=%0d exp=4", k, cyc - last); end
        end
        last = cyc;
        req = req & ~ack;
        k++;
      end
    end
    total++; if (k != 4) begin bad++; $display("FAIL rr_timeout got acks=%0d exp=4", k); end
    tick();
  endtask

  task automatic test_back_to_back_fairness();
    int          exp_v [3] = '{0, 3, 0};
    logic [15:0] exp_p [3] = '{16'd1541, 16'd771, 16'd1541};
    int   k;
    logic reassert;
    rstn = 1'b0;
    req  = '0;
    tick();
    set_note(0, 7'd60); set_note(3, 7'd72);
    rstn = 1'b1;
    tick();
    req = 4'b1001;
    k = 0;
    reassert = 1'b0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      tick();
      if (reassert) begin req[0] = 1'b1; reassert = 1'b0; end
      if (ack != 4'b0) begin
        total++;
        if (ack !== (4'b0001 << exp_v[k]) || rsp_voice !== 3'(exp_v[k]) || rsp_period !== exp_p[k]) begin
          bad++;
          $display("FAIL fair_ack%0d got ack=%b v=%0d p=%0d exp v=%0d p=%0d",
                   k, ack, rsp_voice, rsp_period, exp_v[k], exp_p[k]);
        end
        req = req & ~ack;
        if (k == 0) reassert = 1'b1;
        k++;
      end
    end
    total++; if (k != 3) begin bad++; $display("FAIL fair_timeout got acks=%0d exp=3", k); end
    tick();
  endtask

  task automatic test_async_reset();
    logic got;
    req[2] = 1'b1;
    set_note(2, 7'd64);
    tick();
    tick();
    // now in CAPT; pull reset mid-cycle
    #2;
    rstn = 1'b0;
    #1;
    total++; if (rom_addr !== 7'd69 || rsp_period !== 16'd916) begin bad++; $display("FAIL areset_vals got addr=%0d p=%0d exp 69/916", rom_addr, rsp_period); end
    total++; if (busy !== 1'b0 || rom_en !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL areset_ctl got busy=%b en=%b ack=%b exp 0/0/0000", busy, rom_en, ack); end
    total++; if (rsp_voice !== 3'd0 || rsp_bad !== 1'b0) begin bad++; $display("FAIL areset_rsp got v=%0d b=%b exp 0/0", rsp_voice, rsp_bad); end
    req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (ack !== 4'b0) begin bad++; $display("FAIL areset_noack%0d got=%b exp=0000", c, ack); end
    end
    rstn = 1'b1;
    tick();
    set_note(0, 7'd60); set_note(3, 7'd72);
    req = 4'b1001;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (ack != 4'b0) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL areset_after_timeout got no ack exp ack");
    end else if (ack !== 4'b0001 || rsp_period !== 16'd1541) begin
      bad++; $display("FAIL areset_after got ack=%b p=%0d exp 0001/1541", ack, rsp_period);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_round_robin();
    test_back_to_back_fairness();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
